seq_det_ctrl: RTL
=================

// Module: seq_det_ctrl
// PURPOSE
//  Sequencing controller for the serial 8-bit pattern detector (seq_8) in the CAN controller.
//  Programs the detector by shifting a parallel pattern in under seq_load.
//  Then streams a byte-wide data source into it bit-serially, MSB first.
//  Qualifies and counts the detector's match outputs for the frame/status logic.
// PARAMETERS
//  PAT_W    8   pattern length in bits shifted during programming
//  CNT_W    16  width of saturating match counter
//  DET_LAT  1   detector output latency (cycles after last bit); sets DRAIN length
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  cfg_pattern  in   PAT_W  pattern to program, sampled on accepted cfg_start
//  cfg_start    in   1      start programming; honoured only in IDLE
//  run_en       in   1      level; keep streaming while high
//  byte_in      in   8      stream data byte
//  byte_valid   in   1      byte_in valid
//  byte_ready   out  1      controller can accept byte_in this cycle
//  seq_load     out  1      to detector: pattern-load mode
//  seq_din      out  1      to detector: serial bit
//  seq_dout     in   1      from detector: match indication
//  match_pulse  out  1      one-cycle pulse per qualified match
//  match_count  out  CNT_W  saturating count of qualified matches
//  cfg_done     out  1      one-cycle pulse when programming completes
//  busy         out  1      high in any state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; shift registers, bit counter and match_count cleared.
//  States: IDLE -> LOAD -> STREAM -> DRAIN -> IDLE. Only four states; encoding is free.
//  IDLE:
//   - cfg_start=1: latch cfg_pattern, clear match_count, bit_cnt=PAT_W-1, go to LOAD.
//  LOAD (exactly PAT_W cycles):
//   - seq_load=1; seq_din = pattern MSB first, one bit per cycle.
//   - After the last bit, go to STREAM and pulse cfg_done for 1 cycle (the first STREAM cycle).
//  STREAM:
//   - seq_load=0.
//   - byte_ready=1 when the shifter is empty or on its last bit (bit 0); back-to-back bytes need no bubble.
//   - A byte is accepted on byte_valid&&byte_ready. It is shifted out over the next 8 cycles, MSB first.
//   - seq_din=0 whenever no byte bit is being shifted (bubble).
//   - If run_en=0 and the shifter is empty, byte_ready=0 and go to DRAIN.
//   - If run_en falls mid-byte, the current byte completes first.
//  DRAIN:
//   - DET_LAT cycles; seq_din=0; byte_ready=0; then IDLE.
//  Match qualification:
//   - seq_dout is sampled only in STREAM and DRAIN; it is ignored in IDLE and LOAD.
//   - match_pulse is the registered qualified seq_dout (1-cycle latency).
//   - match_count increments on each match_pulse and saturates at 2^CNT_W-1 (no wrap).
//  Simultaneous events:
//   - cfg_start outside IDLE: ignored.
//   - byte_valid outside STREAM: ignored, byte_ready=0.
//   - cfg_start together with run_en in IDLE: LOAD wins; run_en is irrelevant until STREAM.
//  Reset mid-operation: immediate return to IDLE with outputs 0. The detector is left partially
//  loaded, so a fresh cfg_start is required before further matches are valid.
// TESTING
//  1 cfg_pattern=8'hA5, cfg_start pulse -> seq_load=1 for 8 cycles; seq_din=1,0,1,0,0,1,0,1; cfg_done pulse next cycle; busy=1.
//  2 run_en=1; bytes A5,A5,3C sent back-to-back, seq_dout from a behavioural detector model
//    -> 24 continuous seq_din bits, no bubble; match_count=2; two match_pulse.
//  3 byte_valid low 3 cycles between bytes -> byte_ready stays 1; seq_din=0 during the gap; no spurious match.
//  4 CNT_W=4; force seq_dout=1 for 20 STREAM cycles -> match_count stops at 15.
//  5 cfg_start in STREAM ignored; run_en=0 mid-byte -> byte finishes, DRAIN for DET_LAT cycles, IDLE, busy=0.
//  6 rst_n=0 asynchronously mid-LOAD and mid-STREAM -> all outputs 0 at once; restart from cfg_start works.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl
//   Sequencing controller for the serial 8-bit pattern detector (seq_8).
//   The controller works in three phases:
//     - It programs the detector by shifting a latched pattern in, MSB first, while seq_load is high.
//     - It streams a byte-wide source into the detector bit-serially, MSB first.
//     - It qualifies the detector's match output and counts the matches.
//
// Parameters
//   PAT_W    pattern length shifted during programming
//   CNT_W    width of the saturating match counter
//   DET_LAT  detector output latency; sets the DRAIN length (must be >= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cfg_pattern  pattern to program, sampled when cfg_start is accepted
//   cfg_start    start programming (honoured only in IDLE)
//   run_en       keep streaming while high
//   byte_in      stream data byte
//   byte_valid   byte_in valid
//   byte_ready   controller accepts byte_in this cycle
//   seq_load     to detector: pattern-load mode
//   seq_din      to detector: serial bit
//   seq_dout     from detector: raw match indication
//   match_pulse  one-cycle pulse per qualified match
//   match_count  saturating count of qualified matches
//   cfg_done     one-cycle pulse in the first STREAM cycle
//   busy         high in every state except IDLE
//
// States
//   state     | meaning
//   S_IDLE    | waiting for cfg_start
//   S_LOAD    | shifting the pattern into the detector, PAT_W cycles
//   S_STREAM  | feeding stream bytes bit-serially
//   S_DRAIN   | waiting DET_LAT cycles for the last detector result

module seq_det_ctrl #(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 16,
  parameter int DET_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_start,
  input  logic             run_en,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             seq_load,
  output logic             seq_din,
  input  logic             seq_dout,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_done,
  output logic             busy
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int DW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [PAT_W-1:0] pat_sr;
  logic [BW-1:0]    bit_cnt;
  logic [7:0]       byte_sr;
  logic [3:0]       sh_cnt;     // byte bits still to be shifted out, 0 = empty
  logic [DW-1:0]    drain_cnt;
  logic             match_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cfg_done_q;

  logic             start_ok;
  logic             load_last;
  logic             sh_empty;
  logic             sh_last;
  logic             accept;
  logic             qual_win;

  assign start_ok  = (state == S_IDLE) && cfg_start;
  assign load_last = (state == S_LOAD) && (bit_cnt == '0);
  assign sh_empty  = (sh_cnt == 4'd0);
  assign sh_last   = (sh_cnt == 4'd1);
  assign accept    = byte_valid && byte_ready;
  // The detector result only means anything once the pattern is in place.
  assign qual_win  = (state == S_STREAM) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    seq_load   = 1'b0;
    seq_din    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        seq_load = 1'b1;
        seq_din  = pat_sr[PAT_W-1];
        if (bit_cnt == '0) begin
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        // Accepting on the last bit lets the next byte follow with no bubble.
        byte_ready = sh_last || (sh_empty && run_en);
        seq_din    = !sh_empty && byte_sr[7];
        if (sh_empty && !run_en) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_sr     <= '0;
      bit_cnt    <= '0;
      byte_sr    <= '0;
      sh_cnt     <= 4'd0;
      drain_cnt  <= '0;
      match_q    <= 1'b0;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      cfg_done_q <= load_last;
      match_q    <= qual_win && seq_dout;

      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            pat_sr  <= cfg_pattern;
            bit_cnt <= BW'(PAT_W - 1);
            sh_cnt  <= 4'd0;
          end
        end
        S_LOAD: begin
          pat_sr <= {pat_sr[PAT_W-2:0], 1'b0};
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_STREAM: begin
          if (accept) begin
            byte_sr <= byte_in;
            sh_cnt  <= 4'd8;
          end else if (!sh_empty) begin
            byte_sr <= {byte_sr[6:0], 1'b0};
            sh_cnt  <= sh_cnt - 4'd1;
          end
          if (sh_empty && !run_en) begin
            drain_cnt <= DW'(DET_LAT - 1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase

      // A new programming run restarts the count; otherwise count and hold at all-ones.
      if (start_ok) begin
        cnt_q <= '0;
      end else if (match_q && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign match_pulse = match_q;
  assign match_count = cnt_q;
  assign cfg_done    = cfg_done_q;
  assign busy        = (state != S_IDLE);

endmodule
